tx_app2hip_rr_arbiter: RTL

Parametrised N-port TLP arbiter feeding the HIP Avalon-ST TX interface, for Gen3 and multi-link builds.
- Grants one requester at a time.
- Each granted requester writes one whole TLP burst into an internal unified data+control FIFO.
- The FIFO drains toward the HIP under a configurable ready latency.
- Adds selectable round-robin or fixed-priority arbitration, a configurable room threshold, level reporting and overflow detection.
- Sits between the DMA/register TX sources and the HIP, and feeds the link arbiter with block-done status.

---
 rtl/tx_app2hip_rr_arbiter_if.sv | 54 +++++
 rtl/tx_app2hip_rr_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/tx_app2hip_rr_arbiter_if.sv
// tx_app2hip_rr_arbiter_if: requester/HIP bundle for the TX arbiter plus the shared Avalon-ST control type.
package tx_app2hip_pkg;
  typedef struct packed {
    logic        sop;
    logic        eop;
    logic        valid;
    logic [1:0]  empty;
    logic        err;
    logic [31:0] parity;
  } tx_st_avalon_type;
endpackage

interface tx_app2hip_rr_arbiter_if
  import tx_app2hip_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 256,
  parameter int FIFO_DEPTH = 512,
  parameter int PORTS      = 12
);
  localparam int PORT_WIDTH = $clog2(PORTS);
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;
  logic                            iRR_MODE;
  logic [NUM_REQ-1:0]              iREQ;
  logic [NUM_REQ-1:0]              oGNT;
  tx_st_avalon_type [NUM_REQ-1:0]  iTX_ST;
  logic [NUM_REQ-1:0][DATA_W-1:0]  iTX_ST_DATA;
  logic [PORT_WIDTH-1:0]           iLINK_NUMBER;
  logic                            iBLK_DONE_PULSE;
  logic                            iTX_ST_READY;
  tx_st_avalon_type                oTX_ST;
  logic [DATA_W-1:0]               oTX_ST_DATA;
  logic                            oHIP_BLK_DONE;
  logic [PORT_WIDTH-1:0]           oHIP_LINK_NUMBER;
  logic [LW-1:0]                   oFIFO_LEVEL;
  logic                            oOVERFLOW;
`ifdef TX_ARB_GRANT_WATCHDOG_EN
  logic                            oWDOG_TIMEOUT;
`endif
  modport master (
`ifdef TX_ARB_GRANT_WATCHDOG_EN
    input  oWDOG_TIMEOUT,
`endif
    output iRR_MODE, iREQ, iTX_ST, iTX_ST_DATA, iLINK_NUMBER, iBLK_DONE_PULSE, iTX_ST_READY,
    input  oGNT, oTX_ST, oTX_ST_DATA, oHIP_BLK_DONE, oHIP_LINK_NUMBER, oFIFO_LEVEL, oOVERFLOW
  );
  modport slave (
`ifdef TX_ARB_GRANT_WATCHDOG_EN
    output oWDOG_TIMEOUT,
`endif
    input  iRR_MODE, iREQ, iTX_ST, iTX_ST_DATA, iLINK_NUMBER, iBLK_DONE_PULSE, iTX_ST_READY,
    output oGNT, oTX_ST, oTX_ST_DATA, oHIP_BLK_DONE, oHIP_LINK_NUMBER, oFIFO_LEVEL, oOVERFLOW
  );
endinterface

// File: rtl/tx_app2hip_rr_arbiter.sv
// tx_app2hip_rr_arbiter: N-port TLP arbiter writing whole bursts into a unified FIFO drained toward the HIP.
// Optional grant watchdog: define TX_ARB_GRANT_WATCHDOG_EN.
module tx_app2hip_rr_arbiter
  import tx_app2hip_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 256,
  parameter int FIFO_DEPTH  = 512,
  parameter int ROOM_THRESH = 160,
  parameter int READY_LAT   = 2,
  parameter int OUT_REG     = 1,
  parameter int PORTS       = 12
) (
  input logic iCLK,
  input logic iRST,
  tx_app2hip_rr_arbiter_if.slave bus
);
  localparam int PORT_WIDTH = $clog2(PORTS);
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int GW         = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, REQ, GNT} state_t;
  typedef struct packed {
    logic                  blk;
    logic [PORT_WIDTH-1:0] link;
    tx_st_avalon_type      st;
    logic [DATA_W-1:0]     data;
  } entry_t;
  state_t               r_state;
  logic [NUM_REQ-1:0]   r_gnt, w_req_eff, w_win_oh;
  logic [GW-1:0]        r_gidx, r_ptr, w_base, w_win, w_j;
  logic                 w_go, r_room;
  logic [READY_LAT-1:0] r_rdy;
  logic [READY_LAT:0]   w_rdy_chain;
  logic [AW:0]          r_count;
  logic [AW-1:0]        r_wptr, r_rptr;
  entry_t               r_mem [FIFO_DEPTH];
  entry_t               r_q, w_wdat;
  logic                 r_dv, r_ovf, r_blk;
  logic [PORT_WIDTH-1:0] r_link;
  logic                 w_full, w_empty, w_wr_req, w_wr_en, w_rd_en;
  tx_st_avalon_type     w_gst, w_st;
`ifdef TX_ARB_GRANT_WATCHDOG_EN
  logic [9:0]           r_wdog;
  logic [NUM_REQ-1:0]   r_mask;
  logic                 r_wto;
  assign w_req_eff = bus.iREQ & ~r_mask;
  assign bus.oWDOG_TIMEOUT = r_wto;
`else
  assign w_req_eff = bus.iREQ;
`endif
  // Fixed priority is a round-robin search that always starts just after the top index
  assign w_base = bus.iRR_MODE ? r_ptr : GW'(NUM_REQ - 1);
  always_comb begin
    w_win = '0;
    w_j   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_j = GW'((int'(w_base) + k) % NUM_REQ);
      if (w_req_eff[w_j]) w_win = w_j;
    end
    w_win_oh        = '0;
    w_win_oh[w_win] = 1'b1;
  end
  assign w_go     = (r_state == IDLE) && (|w_req_eff) && r_room;
  assign bus.oGNT = r_gnt | (w_go ? w_win_oh : '0);
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_gidx  <= '0;
      r_ptr   <= GW'(NUM_REQ - 1);
`ifdef TX_ARB_GRANT_WATCHDOG_EN
      r_wdog  <= '0;
      r_mask  <= '0;
      r_wto   <= 1'b0;
`endif
    end else begin
`ifdef TX_ARB_GRANT_WATCHDOG_EN
      r_wto  <= 1'b0;
      r_mask <= r_mask & bus.iREQ;
      r_wdog <= (r_state == GNT && !w_wr_en) ? r_wdog + 10'd1 : 10'd0;
`endif
      case (r_state)
        IDLE: if (w_go) begin
          r_state <= REQ;
          r_gnt   <= w_win_oh;
          r_gidx  <= w_win;
          if (bus.iRR_MODE) r_ptr <= w_win;
        end
        REQ: r_state <= GNT;
        GNT: begin
`ifdef TX_ARB_GRANT_WATCHDOG_EN
          if (r_wdog == 10'h3FF) begin
            r_state        <= IDLE;
            r_gnt          <= '0;
            r_mask[r_gidx] <= 1'b1;
            r_wto          <= 1'b1;
          end else
`endif
          if (!bus.iREQ[r_gidx]) begin
            r_state <= IDLE;
            r_gnt   <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign w_gst       = bus.iTX_ST[r_gidx];
  assign w_full      = r_count[AW];
  assign w_empty     = (r_count == '0);
  assign w_wr_req    = (r_state != IDLE) && w_gst.valid;
  assign w_rd_en     = r_rdy[READY_LAT-1] && !w_empty;
  // A full FIFO still accepts a beat when a read frees the slot in the same cycle
  assign w_wr_en     = w_wr_req && (!w_full || w_rd_en);
  assign w_wdat      = {bus.iBLK_DONE_PULSE & w_gst.valid, bus.iLINK_NUMBER, w_gst, bus.iTX_ST_DATA[r_gidx]};
  assign w_rdy_chain = {r_rdy, bus.iTX_ST_READY};
  always_ff @(posedge iCLK) begin
    if (w_wr_en) r_mem[r_wptr] <= w_wdat;
  end
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_room  <= 1'b0;
      r_ovf   <= 1'b0;
      r_rdy   <= '0;
      r_dv    <= 1'b0;
      r_q     <= '0;
      r_blk   <= 1'b0;
      r_link  <= '0;
    end else begin
      r_rdy   <= w_rdy_chain[READY_LAT-1:0];
      r_count <= r_count + (AW+1)'(w_wr_en) - (AW+1)'(w_rd_en);
      r_room  <= ((FIFO_DEPTH - int'(r_count)) >= ROOM_THRESH) && !w_full;
      r_ovf   <= r_ovf | (w_wr_req & w_full & !w_rd_en);
      r_dv    <= w_rd_en;
      r_blk   <= r_q.blk & r_dv;
      if (r_dv) r_link <= r_q.link;
      if (w_wr_en) r_wptr <= r_wptr + AW'(1);
      if (w_rd_en) begin
        r_q    <= r_mem[r_rptr];
        r_rptr <= r_rptr + AW'(1);
      end
    end
  end
  always_comb begin
    w_st       = r_q.st;
    w_st.sop   = r_q.st.sop & r_dv;
    w_st.eop   = r_q.st.eop & r_dv;
    w_st.valid = r_q.st.valid & r_dv;
  end
  assign bus.oFIFO_LEVEL = r_count;
  assign bus.oOVERFLOW   = r_ovf;
  generate
    if (OUT_REG != 0) begin : g_oreg
      always_ff @(posedge iCLK) begin
        if (iRST) begin
          bus.oTX_ST           <= '0;
          bus.oTX_ST_DATA      <= '0;
          bus.oHIP_BLK_DONE    <= 1'b0;
          bus.oHIP_LINK_NUMBER <= '0;
        end else begin
          bus.oTX_ST           <= w_st;
          bus.oTX_ST_DATA      <= r_q.data;
          bus.oHIP_BLK_DONE    <= r_blk;
          bus.oHIP_LINK_NUMBER <= r_link;
        end
      end
    end else begin : g_ocomb
      assign bus.oTX_ST           = w_st;
      assign bus.oTX_ST_DATA      = r_q.data;
      assign bus.oHIP_BLK_DONE    = r_blk;
      assign bus.oHIP_LINK_NUMBER = r_link;
    end
  endgenerate
endmodule
